// File: rtl/key_repeat.sv
// key_repeat -- button front end for the kitchen timer.
//
// Conditions three active-low push buttons into clean, clock-synchronous
// events: two-flop synchronisation, per-button debounce, one-cycle press and
// release strobes, and optional auto-repeat while a button stays held.
//
// Parameters:
//   DEB_CYCLES  - consecutive stable cycles needed to accept a level change (>= 2)
//   HOLD_CYCLES - cycles from the press strobe to the first repeat strobe (>= 2)
//   REP_CYCLES  - cycles between subsequent repeat strobes (>= 2)
//   REP_EN      - per-button auto-repeat enable, bit i applies to btn[i]
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous, active-high reset
//   btn    in   3  raw buttons, active-low, asynchronous to clk
//   level  out  3  debounced button state, 1 = held
//   press  out  3  one-cycle strobe on each accepted press and each repeat
//   rel    out  3  one-cycle strobe on each accepted release
//                  ("release" is a reserved word in SystemVerilog)

module key_repeat #(
  parameter int         DEB_CYCLES  = 250000,
  parameter int         HOLD_CYCLES = 25000000,
  parameter int         REP_CYCLES  = 5000000,
  parameter logic [2:0] REP_EN      = 3'b011
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic [2:0] level,
  output logic [2:0] press,
  output logic [2:0] rel
);

  localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int RMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Two-flop synchroniser. Both stages reset to 1 so that a reset looks like
  // "all buttons released"; a button held through reset is then seen as a
  // fresh press once it has been debounced.
  logic [2:0] sync_a;
  logic [2:0] sync_b;
  logic [2:0] s;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of the
  // order in which the simulator evaluates the always blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  assign s = ~sync_b;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    logic [DW-1:0] dcnt;
    logic          level_q;
    logic          accept;
    logic [1:0]    state;
    logic [RW-1:0] rcnt;
    logic          press_q;
    logic          rel_q;

    // accept is high in the cycle whose closing edge changes level_q. The
    // FSM acts on it at that same edge, so press/release appear together
    // with the new level instead of one cycle behind it.
    assign accept = (s[i] != level_q) && (dcnt == DEB_LAST);

    // Debounce: count consecutive cycles of disagreement; a single cycle of
    // agreement starts the count over.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dcnt    <= '0;
        level_q <= 1'b0;
      end else if (s[i] == level_q) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        level_q <= s[i];
        dcnt    <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end

    // Repeat FSM. A channel without repeat enabled still passes through
    // HOLD, but its counter stays frozen at zero so it never expires.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state   <= ST_IDLE;
        rcnt    <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        case (state)
          ST_IDLE: begin
            if (accept && s[i]) begin
              press_q <= 1'b1;
              rcnt    <= '0;
              state   <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            // Release is checked first so it wins over a same-cycle expiry.
            if (accept && !s[i]) begin
              rel_q <= 1'b1;
              rcnt  <= '0;
              state <= ST_IDLE;
            end else if (REP_EN[i]) begin
              if (rcnt == HOLD_LAST) begin
                press_q <= 1'b1;
                rcnt    <= '0;
                state   <= ST_REPEAT;
              end else begin
                rcnt <= rcnt + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (accept && !s[i]) begin
              rel_q <= 1'b1;
              rcnt  <= '0;
              state <= ST_IDLE;
            end else if (rcnt == REP_LAST) begin
              press_q <= 1'b1;
              rcnt    <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
  end

endmodule

// File: tb/tb_key_repeat.sv
// tb_key_repeat -- self-checking bench for key_repeat with short timing
// (DEB_CYCLES=4, HOLD_CYCLES=20, REP_CYCLES=5, REP_EN=3'b011).
//
// A negedge monitor logs every press/release strobe with its cycle number.
// Table segments hold a button pattern for a number of cycles and compare
// strobe counts and final levels; hand-written sequences compare exact
// strobe cycles, release at repeat expiry and reset during a hold.

module tb_key_repeat;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic [2:0] level;
  logic [2:0] press;
  logic [2:0] rel;

  key_repeat #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(20),
    .REP_CYCLES (5),
    .REP_EN     (3'b011)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .level(level),
    .press(press),
    .rel  (rel)
  );

  always #5 clk = ~clk;

  // cyc == n from just after rising edge n until rising edge n+1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    bit is_rel;
  } ev_t;

  ev_t evq[$];
  int  overlap = 0;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < 3; i++) begin
        if (press[i] === 1'b1) evq.push_back('{cyc, i, 1'b0});
        if (rel[i] === 1'b1)   evq.push_back('{cyc, i, 1'b1});
        if (press[i] === 1'b1 && rel[i] === 1'b1) overlap++;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int count_ev(int ch, bit is_rel, int lo, int hi);
    int n = 0;
    foreach (evq[k])
      if (evq[k].ch == ch && evq[k].is_rel == is_rel && evq[k].cyc > lo && evq[k].cyc <= hi)
        n++;
    return n;
  endfunction

  // Cycle offset (from lo) of the idx-th matching strobe in (lo, hi], or -1.
  function automatic int nth_ev(int ch, bit is_rel, int lo, int hi, int idx);
    int n = 0;
    foreach (evq[k])
      if (evq[k].ch == ch && evq[k].is_rel == is_rel && evq[k].cyc > lo && evq[k].cyc <= hi) begin
        if (n == idx) return evq[k].cyc - lo;
        n++;
      end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    string          name;
    logic [2:0]     btn;
    logic [2:0]     tgl;
    int             half;
    int             n;
    logic [2:0][7:0] exp_press;
    logic [2:0][7:0] exp_rel;
    logic [2:0]     exp_level;
  } seg_t;

  seg_t segs[$];

  task automatic add_seg(input string name, input logic [2:0] b, input logic [2:0] tgl,
                         input int half, input int n, input logic [2:0][7:0] ep,
                         input logic [2:0][7:0] er, input logic [2:0] el);
    seg_t sg;
    sg.name = name; sg.btn = b; sg.tgl = tgl; sg.half = half; sg.n = n;
    sg.exp_press = ep; sg.exp_rel = er; sg.exp_level = el;
    segs.push_back(sg);
  endtask

  // Hand-computed strobe schedule for one held, repeating channel:
  // press at +6, repeats at +26, +31, +36.
  int exp_p[4] = '{6, 26, 31, 36};

  initial begin
    int         n0;
    int         r;
    logic [2:0] cur;

    // Packed expectation arrays are {ch2, ch1, ch0}.
    add_seg("clean_press",  3'b110, 3'b000, 0, 100, {8'd0, 8'd0, 8'd16}, {8'd0, 8'd0, 8'd0}, 3'b001);
    add_seg("release0",     3'b111, 3'b000, 0,  10, {8'd0, 8'd0, 8'd1},  {8'd0, 8'd0, 8'd1}, 3'b000);
    add_seg("bounce1",      3'b101, 3'b010, 3,  30, {8'd0, 8'd0, 8'd0},  {8'd0, 8'd0, 8'd0}, 3'b000);
    add_seg("quiet",        3'b111, 3'b000, 0,  10, {8'd0, 8'd0, 8'd0},  {8'd0, 8'd0, 8'd0}, 3'b000);
    add_seg("no_repeat2",   3'b011, 3'b000, 0, 100, {8'd1, 8'd0, 8'd0},  {8'd0, 8'd0, 8'd0}, 3'b100);
    add_seg("release2",     3'b111, 3'b000, 0,  10, {8'd0, 8'd0, 8'd0},  {8'd1, 8'd0, 8'd0}, 3'b000);
    add_seg("all_pressed",  3'b000, 3'b000, 0,  40, {8'd1, 8'd4, 8'd4},  {8'd0, 8'd0, 8'd0}, 3'b111);
    add_seg("all_released", 3'b111, 3'b000, 0,  10, {8'd0, 8'd1, 8'd1},  {8'd1, 8'd1, 8'd1}, 3'b000);

    // Reset state.
    btn = 3'b111;
    rst = 1'b1;
    repeat (3) tick();
    sample();
    check("reset level", level, 3'b000);
    check("reset press", press, 3'b000);
    check("reset rel",   rel,   3'b000);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    sample();
    check("idle level", level, 3'b000);

    // Table-driven segments; each drives just after a negedge and closes its
    // strobe window N cycles later.
    foreach (segs[j]) begin
      n0  = cyc;
      cur = segs[j].btn;
      btn = cur;
      for (int k = 1; k <= segs[j].n; k++) begin
        tick();
        if (segs[j].half > 0 && k < segs[j].n && (k % segs[j].half) == 0) begin
          cur = cur ^ segs[j].tgl;
          btn = cur;
        end
      end
      sample();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("%s press[%0d] count", segs[j].name, i),
              count_ev(i, 1'b0, n0, n0 + segs[j].n), 32'(segs[j].exp_press[i]));
        check($sformatf("%s rel[%0d] count", segs[j].name, i),
              count_ev(i, 1'b1, n0, n0 + segs[j].n), 32'(segs[j].exp_rel[i]));
      end
      check($sformatf("%s level", segs[j].name), level, segs[j].exp_level);
    end

    // Exact schedule on btn[0], released so that level falls on the same
    // edge as the repeat expiry that would have produced a press at +41.
    n0  = cyc;
    btn = 3'b110;
    repeat (35) tick();
    btn = 3'b111;
    repeat (15) tick();
    sample();
    check("sched press count", count_ev(0, 1'b0, n0, n0 + 50), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("sched press #%0d cycle", k), nth_ev(0, 1'b0, n0, n0 + 50, k), exp_p[k]);
    check("expiry rel count", count_ev(0, 1'b1, n0, n0 + 50), 1);
    check("expiry rel cycle", nth_ev(0, 1'b1, n0, n0 + 50, 0), 41);

    // Reset in the middle of REPEAT with btn[0] still held.
    n0  = cyc;
    btn = 3'b110;
    repeat (33) tick();
    check("pre-reset level", level, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check("async reset level", level, 3'b000);
    check("async reset press", press, 3'b000);
    check("async reset rel",   rel,   3'b000);
    tick();
    tick();
    rst = 1'b0;
    r = cyc;
    check("pre-reset press count", count_ev(0, 1'b0, n0, r), 3);
    check("pre-reset rel count",   count_ev(0, 1'b1, n0, r), 0);
    repeat (33) tick();
    btn = 3'b111;
    repeat (12) tick();
    sample();
    check("post-reset press count", count_ev(0, 1'b0, r, r + 45), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("post-reset press #%0d cycle", k), nth_ev(0, 1'b0, r, r + 45, k), exp_p[k]);
    check("post-reset rel cycle", nth_ev(0, 1'b1, r, r + 45, 0), 39);
    check("post-reset other presses", count_ev(1, 1'b0, r, r + 45) + count_ev(2, 1'b0, r, r + 45), 0);

    check("press/rel overlap cycles", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
